// File: rtl/rw_core_arbiter.sv
// Round-robin arbiter sharing one streaming core between N requesters; each burst is
// captured into an id-tagged output FIFO. Define RW_ARB_PRIO0_EN to give requester 0 fixed priority.
module rw_core_arbiter #(
  parameter int N     = 4,
  parameter int DEPTH = 16,
  parameter int LW    = 5,
  parameter int IDW   = 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   req,
  input  logic [N-1:0]   req_mode,
  input  logic [LW-1:0]  burst_len,
  output logic [N-1:0]   gnt,
  output logic [N-1:0]   done,
  output logic           dev_rst,
  output logic           dev_in,
  input  logic [7:0]     dev_out,
  output logic           m_valid,
  input  logic           m_ready,
  output logic [7:0]     m_data,
  output logic [IDW-1:0] m_id,
  output logic [1:0]     dbg_state
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int MW = (LW > CW) ? LW : CW;

  typedef enum logic [1:0] {IDLE = 2'd0, DEVRST = 2'd1, RUN = 2'd2} state_e;

  state_e         state_q, state_d;
  logic [IDW-1:0] id_q, id_d, last_q, last_d;
  logic           mode_q, mode_d;
  logic [LW-1:0]  len_q, len_d, cnt_q, cnt_d;
  logic [N-1:0]   gnt_q, gnt_d, done_q, done_d;
  logic           dev_rst_q, dev_rst_d, dev_in_q, dev_in_d;

  logic [IDW+7:0] mem_q [DEPTH];
  logic [AW-1:0]  wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0]  count_q, count_d;
  logic           push, pop;

  logic [N-1:0]   elig;
  logic [MW-1:0]  free_w;
  logic           found;
  logic [IDW-1:0] win, cand;
  int             rr_idx;

  assign m_valid = (count_q != '0);
  assign {m_id, m_data} = mem_q[rd_q];
  assign push = (state_q == RUN);
  assign pop  = m_valid && m_ready;

  // Admission uses the registered occupancy; a pop this cycle is not credited.
  always_comb begin
    free_w = MW'(DEPTH) - MW'(count_q);
    for (int i = 0; i < N; i++)
      elig[i] = req[i] && (burst_len != '0) && (MW'(burst_len) <= free_w);
    found  = 1'b0;
    win    = '0;
    rr_idx = 0;
    cand   = '0;
`ifdef RW_ARB_PRIO0_EN
    if (elig[0]) begin
      found = 1'b1;
      win   = '0;
    end
`endif
    for (int k = 1; k <= N; k++) begin
      rr_idx = (int'(last_q) + k) % N;
      cand   = IDW'(rr_idx);
`ifdef RW_ARB_PRIO0_EN
      if (!found && (rr_idx != 0) && elig[cand]) begin
`else
      if (!found && elig[cand]) begin
`endif
        found = 1'b1;
        win   = cand;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    mode_d  = mode_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    done_d  = '0;
    case (state_q)
      IDLE: begin
        if (found) begin
          state_d = DEVRST;
          id_d    = win;
          mode_d  = req_mode[win];
          len_d   = burst_len;
        end
      end
      DEVRST: begin
        state_d = RUN;
        cnt_d   = '0;
      end
      RUN: begin
        cnt_d = cnt_q + LW'(1);
        if (cnt_q == len_q - LW'(1)) begin
          state_d = IDLE;
          done_d  = N'(1) << id_q;
`ifdef RW_ARB_PRIO0_EN
          if (id_q != '0) last_d = id_q;
`else
          last_d = id_q;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
    // Outputs are registered, so they are decoded from the next state.
    gnt_d     = (state_d == IDLE) ? '0 : (N'(1) << id_d);
    dev_rst_d = (state_d == DEVRST);
    dev_in_d  = (state_d != IDLE) && mode_d;
    wr_d      = push ? wr_q + AW'(1) : wr_q;
    rd_d      = pop ? rd_q + AW'(1) : rd_q;
    count_d   = count_q + CW'(push) - CW'(pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      id_q      <= '0;
      mode_q    <= 1'b0;
      len_q     <= '0;
      cnt_q     <= '0;
      last_q    <= IDW'(N - 1);
      gnt_q     <= '0;
      done_q    <= '0;
      dev_rst_q <= 1'b1;
      dev_in_q  <= 1'b0;
      wr_q      <= '0;
      rd_q      <= '0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      id_q      <= id_d;
      mode_q    <= mode_d;
      len_q     <= len_d;
      cnt_q     <= cnt_d;
      last_q    <= last_d;
      gnt_q     <= gnt_d;
      done_q    <= done_d;
      dev_rst_q <= dev_rst_d;
      dev_in_q  <= dev_in_d;
      wr_q      <= wr_d;
      rd_q      <= rd_d;
      count_q   <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= {id_q, dev_out};
  end

  assign gnt       = gnt_q;
  assign done      = done_q;
  assign dev_rst   = dev_rst_q;
  assign dev_in    = dev_in_q;
  assign dbg_state = state_q;

`ifndef SYNTHESIS
  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(push && !pop && (count_q == CW'(DEPTH))));
`endif
endmodule

// File: tb/tb_rw_core_arbiter.sv
// Bench for rw_core_arbiter: burst-schedule reference model, vector table, directed corner sequences
// and randomized traffic. Build with RW_ARB_PRIO0_EN to exercise the fixed-priority variant.
module tb_rw_core_arbiter;
  localparam int N = 4, DEPTH = 16, LW = 5, IDW = 2;

  logic           clk, rst;
  logic [N-1:0]   req, req_mode, gnt, done;
  logic [LW-1:0]  burst_len;
  logic           dev_rst, dev_in, m_valid, m_ready;
  logic [7:0]     dev_out, m_data;
  logic [IDW-1:0] m_id;
  logic [1:0]     dbg_state;

  int n_vec = 0, n_err = 0;

  rw_core_arbiter #(.N(N), .DEPTH(DEPTH), .LW(LW), .IDW(IDW)) dut (
    .clk(clk), .rst(rst), .req(req), .req_mode(req_mode), .burst_len(burst_len),
    .gnt(gnt), .done(done), .dev_rst(dev_rst), .dev_in(dev_in), .dev_out(dev_out),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_id(m_id), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset / core stub ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  logic [7:0] core_cnt;
  always @(posedge clk) begin
    if (dev_rst) core_cnt <= 8'd0;
    else         core_cnt <= core_cnt + 8'd1;
  end
  assign dev_out = core_cnt;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = '0;
    tick();
    rst = 1'b0;
  endtask

  // ---------------- reference model: burst schedule by cycle number ----------------
  int  cyc = 0, w_start = 0, w_len = 0, w_id = 0, m_count = 0, m_last = N - 1;
  bit  w_mode = 0, w_act = 0, rst_prev = 1;
  logic [IDW+7:0] exp_q[$];

  function automatic int pick(input logic [N-1:0] r, input int blen, input int cnt, input int last);
    bit ok[N];
    for (int i = 0; i < N; i++) ok[i] = r[i] && (blen > 0) && (blen <= DEPTH - cnt);
`ifdef RW_ARB_PRIO0_EN
    if (ok[0]) return 0;
`endif
    for (int k = 1; k <= N; k++) begin
      int idx = (last + k) % N;
`ifdef RW_ARB_PRIO0_EN
      if (idx != 0 && ok[idx]) return idx;
`else
      if (ok[idx]) return idx;
`endif
    end
    return -1;
  endfunction

  always @(negedge clk) begin : monitor
    logic [N-1:0]   e_gnt, e_done;
    logic           e_rst, e_in;
    bit             push;
    logic [7:0]     pdata;
    logic [IDW+7:0] head;
    int             win, cnt0;
    e_gnt = '0; e_done = '0; e_rst = rst_prev; e_in = 1'b0; push = 0; pdata = '0;
    cnt0 = m_count;
    if (w_act) begin
      if (cyc >= w_start && cyc <= w_start + w_len) begin
        e_gnt = N'(1) << w_id;
        e_in  = w_mode;
      end
      if (cyc == w_start) e_rst = 1'b1;
      if (cyc > w_start && cyc <= w_start + w_len) begin
        push  = 1;
        pdata = 8'(cyc - w_start - 1);
      end
      if (cyc == w_start + w_len + 1) e_done = N'(1) << w_id;
    end
    check("gnt", gnt, e_gnt);
    check("done", done, e_done);
    check("dev_rst", dev_rst, e_rst);
    check("dev_in", dev_in, e_in);
    check("m_valid", m_valid, m_count > 0);
    if (m_count > 0 && m_ready) begin
      head = exp_q.pop_front();
      check("m_head", {m_id, m_data}, head);
      m_count--;
    end
    if (push) begin
      exp_q.push_back({IDW'(w_id), pdata});
      m_count++;
    end
    if (!rst && (!w_act || cyc > w_start + w_len)) begin
      win = pick(req, int'(burst_len), cnt0, m_last);
      if (win >= 0) begin
        w_act = 1; w_start = cyc + 1; w_len = int'(burst_len); w_id = win; w_mode = req_mode[win];
`ifdef RW_ARB_PRIO0_EN
        if (win != 0) m_last = win;
`else
        m_last = win;
`endif
      end
    end
    if (rst) begin
      exp_q.delete(); m_count = 0; m_last = N - 1; w_act = 0; rst_prev = 1;
    end else rst_prev = 0;
    cyc++;
  end

  // ---------------- helpers for directed sequences ----------------
  function automatic int oh2id(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic collect(input int n, output int ids[8], output int gaps[8]);
    logic [N-1:0] prev;
    int got, zeros;
    prev = gnt; got = 0; zeros = 0;
    for (int k = 0; k < 8; k++) begin ids[k] = -1; gaps[k] = -1; end
    for (int c = 0; c < 200 && got < n; c++) begin
      @(negedge clk);
      if (gnt != '0 && prev == '0) begin
        ids[got] = oh2id(gnt); gaps[got] = zeros; got++;
      end
      zeros = (gnt == '0) ? zeros + 1 : 0;
      prev = gnt;
    end
  endtask

  task automatic wait_gnt(input int bound, output logic [N-1:0] got);
    got = '0;
    for (int k = 0; k < bound && got == '0; k++) begin
      @(negedge clk);
      got = gnt;
    end
  endtask

  typedef struct {
    logic [N-1:0]  req;
    logic [N-1:0]  mode;
    logic [LW-1:0] blen;
    logic [N-1:0]  exp_gnt;
    int            wait_cyc;
  } vec_t;

  vec_t tbl[8];

  initial begin : stim
    int ids[8], gaps[8];
    int cnt_g, cnt_d, cnt_r, cnt_i;
    logic [N-1:0] got;

    tbl[0] = '{4'b0001, 4'b0001, 5'd3,  4'b0001, 4};
    tbl[1] = '{4'b1010, 4'b0000, 5'd2,  4'b0010, 4};
    tbl[2] = '{4'b1100, 4'b0100, 5'd5,  4'b0100, 4};
    tbl[3] = '{4'b1000, 4'b1000, 5'd1,  4'b1000, 4};
    tbl[4] = '{4'b0001, 4'b0001, 5'd0,  4'b0000, 50};
    tbl[5] = '{4'b0001, 4'b0001, 5'd20, 4'b0000, 50};
    tbl[6] = '{4'b0110, 4'b0010, 5'd16, 4'b0010, 4};
    tbl[7] = '{4'b0110, 4'b0010, 5'd17, 4'b0000, 50};

    rst = 1'b1; req = '0; req_mode = '0; burst_len = '0; m_ready = 1'b1;
    repeat (2) tick();
    rst = 1'b0;

    // Single burst: 4 grant cycles, one DEVRST cycle, dev_in follows mode, one done pulse.
    do_reset();
    req = 4'b0001; req_mode = 4'b0001; burst_len = 5'd3; m_ready = 1'b1;
    @(negedge clk);
    tick();
    req = '0;
    cnt_g = 0; cnt_d = 0; cnt_r = 0; cnt_i = 0;
    for (int c = 0; c < 11; c++) begin
      @(negedge clk);
      if (gnt == 4'b0001) cnt_g++;
      if (done != '0) cnt_d++;
      if (dev_rst) cnt_r++;
      if (dev_in) cnt_i++;
    end
    check("single_gnt_cycles", cnt_g, 4);
    check("single_done_pulses", cnt_d, 1);
    check("single_devrst_cycles", cnt_r, 1);
    check("single_devin_cycles", cnt_i, 4);

`ifdef RW_ARB_PRIO0_EN
    do_reset();
    req = 4'b1111; burst_len = 5'd1;
    collect(3, ids, gaps);
    for (int k = 0; k < 3; k++) check("prio_order", ids[k], 0);
    tick();
    req = 4'b1110;
    collect(4, ids, gaps);
    check("prio_rr_0", ids[0], 1);
    check("prio_rr_1", ids[1], 2);
    check("prio_rr_2", ids[2], 3);
    check("prio_rr_3", ids[3], 1);
`else
    do_reset();
    req = 4'b1111; req_mode = 4'b0101; burst_len = 5'd2;
    collect(5, ids, gaps);
    check("rr_order_0", ids[0], 0);
    check("rr_order_1", ids[1], 1);
    check("rr_order_2", ids[2], 2);
    check("rr_order_3", ids[3], 3);
    check("rr_order_4", ids[4], 0);
    for (int k = 1; k < 5; k++) check("rr_gap", gaps[k], 1);
`endif

    // Back-pressure: two 6-sample bursts fill 12 entries, the third waits for free space.
    tick();
    do_reset();
    req = 4'b0011; req_mode = 4'b0010; burst_len = 5'd6; m_ready = 1'b0;
    repeat (30) tick();
    @(negedge clk);
    check("full_withheld_gnt", gnt, 4'b0000);
    check("full_m_valid", m_valid, 1'b1);
    tick();
    m_ready = 1'b1;
    repeat (2) tick();
    m_ready = 1'b0;
    wait_gnt(4, got);
    check("after_pop_gnt", got, 4'b0001);
    tick();
    m_ready = 1'b1;
    repeat (30) tick();

    // Reset in the middle of a burst.
    do_reset();
    req = 4'b0001; req_mode = 4'b0000; burst_len = 5'd8;
    wait_gnt(5, got);
    check("midrst_first_gnt", got, 4'b0001);
    repeat (3) tick();
    rst = 1'b1; req = 4'b1010;
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("midrst_m_valid", m_valid, 1'b0);
    check("midrst_dev_rst", dev_rst, 1'b1);
    check("midrst_gnt", gnt, 4'b0000);
    check("midrst_done", done, 4'b0000);
    wait_gnt(4, got);
    check("midrst_next_gnt", got, 4'b0010);
    tick();
    req = '0;
    repeat (12) tick();

    // Oversized request becomes grantable as soon as the length is corrected.
    do_reset();
    req = 4'b0001; burst_len = 5'd20;
    repeat (10) tick();
    burst_len = 5'd4;
    @(negedge clk);
    tick();
    @(negedge clk);
    check("blen_fix_gnt", gnt, 4'b0001);
    tick();
    req = '0;
    repeat (10) tick();

    for (int i = 0; i < 8; i++) begin
      do_reset();
      req = tbl[i].req; req_mode = tbl[i].mode; burst_len = tbl[i].blen; m_ready = 1'b1;
      wait_gnt(tbl[i].wait_cyc, got);
      check("tbl_gnt", got, tbl[i].exp_gnt);
      tick();
      req = '0;
      repeat (20) tick();
    end

    // Random traffic, checked cycle by cycle by the monitor.
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 3) == 0) req = N'($urandom_range(0, 15));
      req_mode  = N'($urandom_range(0, 15));
      burst_len = LW'($urandom_range(0, 18));
      m_ready   = ($urandom_range(0, 3) != 0);
      rst       = ($urandom_range(0, 299) == 0);
      tick();
    end
    rst = 1'b0; req = '0; m_ready = 1'b1;
    repeat (40) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin : watchdog
    #1000000;
    n_err++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
